// File: rtl/pc_gen.sv
// pc_gen: program counter generator with branch/jump resolution, halt state
// and a circular return-address stack.
//   clk            in   rising-edge clock
//   rst            in   asynchronous active-low reset
//   instr          in   fetched instruction, opcode in instr[15:11]
//   rs             in   register operand for JR/JALR targets
//   ext_imm        in   sign-extended immediate/displacement
//   branch_taken   in   resolved condition for opcode 011xx
//   stall          in   hold PC, state and RAS
//   redirect_valid in   late-stage flush request (highest priority)
//   redirect_pc    in   flush target
//   instr_addr     out  current PC (registered)
//   pc_plus        out  instr_addr + INC
//   halt           out  high while HALTED
//   ras_top        out  newest RAS entry, 0 when empty
//   ras_empty      out  RAS holds no entries
module pc_gen #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter int               INC       = 2,
    parameter int               RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      instr,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] ext_imm,
    input  logic             branch_taken,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic [WIDTH-1:0] instr_addr,
    output logic [WIDTH-1:0] pc_plus,
    output logic             halt,
    output logic [WIDTH-1:0] ras_top,
    output logic             ras_empty
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [0:0] RUN    = 1'b0;
    localparam logic [0:0] HALTED = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [WIDTH-1:0] ras_d [RAS_DEPTH];
    logic [PW-1:0]    wr_q, wr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [4:0]       opc;
    logic             is_br, is_j, is_jr, is_jal, is_jalr, is_halt, run, adv, push, pop;
    logic [WIDTH-1:0] tgt;
    logic             unused_instr;

    assign unused_instr = ^instr[10:0];
    assign instr_addr   = pc_q;
    assign pc_plus      = pc_q + WIDTH'(INC);
    assign halt         = state_q == HALTED;
    assign ras_empty    = cnt_q == '0;
    // wr_q points at the next free slot, so the newest entry sits just below it
    assign ras_top      = ras_empty ? '0 : ras_q[wr_q - PW'(1)];

    always_comb begin
        opc     = instr[15:11];
        is_br   = opc[4:2] == 3'b011;
        is_j    = opc == 5'b00100;
        is_jr   = opc == 5'b00101;
        is_jal  = opc == 5'b00110;
        is_jalr = opc == 5'b00111;
        is_halt = opc == 5'b00000;
        run     = state_q == RUN;
        adv     = !redirect_valid && !stall && run && !is_halt;
        tgt     = is_br ? (branch_taken ? pc_plus + ext_imm : pc_plus) :
                  (is_j || is_jal) ? pc_plus + ext_imm :
                  (is_jr || is_jalr) ? rs + ext_imm : pc_plus;
        pc_d    = redirect_valid ? redirect_pc : adv ? tgt : pc_q;
        state_d = redirect_valid ? RUN : (!stall && run && is_halt) ? HALTED : state_q;
        push    = adv && (is_jal || is_jalr);
        // popping an empty stack is a no-op
        pop     = adv && is_jr && !ras_empty;
        ras_d   = ras_q;
        if (push) ras_d[wr_q] = pc_plus;
        wr_d    = push ? wr_q + PW'(1) : pop ? wr_q - PW'(1) : wr_q;
        // a push when full overwrites the oldest slot; count saturates
        cnt_d   = push ? (cnt_q == CW'(RAS_DEPTH) ? cnt_q : cnt_q + CW'(1)) :
                  pop ? cnt_q - CW'(1) : cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            ras_q   <= '{default: '0};
            wr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ras_q   <= ras_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed self-checking bench for pc_gen with default parameters.
module tb_pc_gen;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] instr = 16'h8000;
    logic [15:0] rs = '0;
    logic [15:0] ext_imm = '0;
    logic        branch_taken = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic [15:0] instr_addr, pc_plus, ras_top;
    logic        halt, ras_empty;
    int          checks = 0;
    int          errors = 0;

    localparam logic [15:0] NOP  = 16'h8000;
    localparam logic [15:0] HLT  = 16'h0000;
    localparam logic [15:0] BR   = 16'h6000;
    localparam logic [15:0] JR   = 16'h2800;
    localparam logic [15:0] JAL  = 16'h3000;

    pc_gen dut (
        .clk(clk), .rst(rst), .instr(instr), .rs(rs), .ext_imm(ext_imm),
        .branch_taken(branch_taken), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .instr_addr(instr_addr), .pc_plus(pc_plus),
        .halt(halt), .ras_top(ras_top), .ras_empty(ras_empty)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_to(input logic [15:0] pc);
        redirect_valid = 1'b1;
        redirect_pc = pc;
        step();
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (instr_addr !== 16'h0000) begin errors++; $display("FAIL reset_pc got %h exp 0000", instr_addr); end
        checks++; if (halt !== 1'b0) begin errors++; $display("FAIL reset_halt got %b exp 0", halt); end
        checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL reset_ras_empty got %b exp 1", ras_empty); end
        checks++; if (ras_top !== 16'h0000) begin errors++; $display("FAIL reset_ras_top got %h exp 0000", ras_top); end
        checks++; if (pc_plus !== 16'h0002) begin errors++; $display("FAIL reset_pc_plus got %h exp 0002", pc_plus); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_sequential();
        logic [15:0] exp [3] = '{16'h0002, 16'h0004, 16'h0006};
        instr = NOP;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (instr_addr !== exp[i]) begin errors++; $display("FAIL seq_%0d got %h exp %h", i, instr_addr, exp[i]); end
        end
    endtask

    task automatic test_branch_wrap();
        go_to(16'hFFFE);
        checks++; if (pc_plus !== 16'h0000) begin errors++; $display("FAIL wrap_pc_plus got %h exp 0000", pc_plus); end
        instr = BR; branch_taken = 1'b1; ext_imm = 16'h0004;
        step();
        checks++; if (instr_addr !== 16'h0004) begin errors++; $display("FAIL br_taken got %h exp 0004", instr_addr); end
        go_to(16'hFFFE);
        instr = BR; branch_taken = 1'b0;
        step();
        checks++; if (instr_addr !== 16'h0000) begin errors++; $display("FAIL br_not_taken got %h exp 0000", instr_addr); end
        instr = NOP; ext_imm = '0;
    endtask

    task automatic test_jal_jr();
        go_to(16'h0010);
        instr = JAL; ext_imm = 16'h0020;
        step();
        checks++; if (instr_addr !== 16'h0032) begin errors++; $display("FAIL jal_pc got %h exp 0032", instr_addr); end
        checks++; if (ras_top !== 16'h0012) begin errors++; $display("FAIL jal_ras_top got %h exp 0012", ras_top); end
        checks++; if (ras_empty !== 1'b0) begin errors++; $display("FAIL jal_ras_empty got %b exp 0", ras_empty); end
        instr = JR; rs = 16'h0012; ext_imm = 16'h0000;
        step();
        checks++; if (instr_addr !== 16'h0012) begin errors++; $display("FAIL jr_pc got %h exp 0012", instr_addr); end
        checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL jr_ras_empty got %b exp 1", ras_empty); end
        checks++; if (ras_top !== 16'h0000) begin errors++; $display("FAIL jr_ras_top got %h exp 0000", ras_top); end
        instr = NOP;
    endtask

    task automatic test_ras_overflow();
        logic [15:0] pcs [5] = '{16'h0112, 16'h0124, 16'h0136, 16'h0148, 16'h015A};
        logic [15:0] tops [5] = '{16'h014A, 16'h0138, 16'h0126, 16'h0114, 16'h0000};
        go_to(16'h0100);
        instr = JAL; ext_imm = 16'h0010;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (instr_addr !== pcs[i]) begin errors++; $display("FAIL ovf_jal_%0d got %h exp %h", i, instr_addr, pcs[i]); end
        end
        instr = JR; rs = 16'h0200; ext_imm = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            checks++; if (ras_top !== tops[i]) begin errors++; $display("FAIL ovf_top_%0d got %h exp %h", i, ras_top, tops[i]); end
            step();
            checks++; if (instr_addr !== 16'h0200) begin errors++; $display("FAIL ovf_jr_pc_%0d got %h exp 0200", i, instr_addr); end
        end
        checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL ovf_empty got %b exp 1", ras_empty); end
        checks++; if (ras_top !== 16'h0000) begin errors++; $display("FAIL ovf_top_empty got %h exp 0000", ras_top); end
        instr = NOP;
    endtask

    task automatic test_halt_stall_redirect();
        go_to(16'h0080);
        stall = 1'b1; instr = JAL; ext_imm = 16'h0010;
        step();
        checks++; if (instr_addr !== 16'h0080) begin errors++; $display("FAIL stall_pc got %h exp 0080", instr_addr); end
        checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL stall_no_push got %b exp 1", ras_empty); end
        stall = 1'b0; instr = NOP; ext_imm = '0;
        go_to(16'h0040);
        instr = HLT;
        step();
        checks++; if (halt !== 1'b1) begin errors++; $display("FAIL halt_set got %b exp 1", halt); end
        checks++; if (instr_addr !== 16'h0040) begin errors++; $display("FAIL halt_pc got %h exp 0040", instr_addr); end
        instr = NOP;
        step();
        checks++; if (halt !== 1'b1 || instr_addr !== 16'h0040) begin errors++; $display("FAIL halt_hold got halt=%b pc=%h exp 1/0040", halt, instr_addr); end
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0100;
        step();
        redirect_valid = 1'b0; stall = 1'b0;
        checks++; if (instr_addr !== 16'h0100) begin errors++; $display("FAIL redirect_pc got %h exp 0100", instr_addr); end
        checks++; if (halt !== 1'b0) begin errors++; $display("FAIL redirect_halt got %b exp 0", halt); end
        step();
        checks++; if (instr_addr !== 16'h0102) begin errors++; $display("FAIL resume_pc got %h exp 0102", instr_addr); end
    endtask

    task automatic test_async_reset();
        instr = JAL; ext_imm = 16'h0000;
        step();
        instr = HLT;
        step();
        checks++; if (halt !== 1'b1 || ras_empty !== 1'b0) begin errors++; $display("FAIL pre_reset got halt=%b empty=%b exp 1/0", halt, ras_empty); end
        #3 rst = 1'b0;
        #1;
        checks++; if (instr_addr !== 16'h0000) begin errors++; $display("FAIL async_pc got %h exp 0000", instr_addr); end
        checks++; if (halt !== 1'b0) begin errors++; $display("FAIL async_halt got %b exp 0", halt); end
        checks++; if (ras_empty !== 1'b1 || ras_top !== 16'h0000) begin errors++; $display("FAIL async_ras got empty=%b top=%h exp 1/0000", ras_empty, ras_top); end
        instr = NOP;
        #1 rst = 1'b1;
        step();
        checks++; if (instr_addr !== 16'h0002) begin errors++; $display("FAIL post_reset_pc got %h exp 0002", instr_addr); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch_wrap();
        test_jal_jr();
        test_ras_overflow();
        test_halt_stall_redirect();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
